// File: rtl/systolic_mm_engine_if.sv
// Operand-beat and result-row streams of the systolic matrix-multiply engine.
// The engine connects through the slave modport; the operand/result side uses master.
interface systolic_mm_engine_if #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 48
);
    localparam int ROW_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [ARR_SIZE*DATA_W-1:0]   a_col;
    logic [ARR_SIZE*DATA_W-1:0]   b_row;
    logic                         out_valid;
    logic                         out_ready;
    logic [ARR_SIZE*ACC_W-1:0]    out_data;
    logic [ROW_W-1:0]             out_row_idx;

    modport slave (
        input  in_valid, a_col, b_row, out_ready,
        output in_ready, out_valid, out_data, out_row_idx
    );

    modport master (
        output in_valid, a_col, b_row, out_ready,
        input  in_ready, out_valid, out_data, out_row_idx
    );
endinterface

// File: rtl/systolic_mm_engine.sv
// Output-stationary ARR_SIZE x ARR_SIZE systolic matmul: C = A(N x k) * B(k x N),
// with on-chip operand skewing, job FSM and a row-by-row result drain.
module systolic_mm_engine #(
    parameter int ARR_SIZE = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 48,
    parameter int K_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mode,
    input  logic                   start,
    input  logic [K_W-1:0]         k_len,
    systolic_mm_engine_if.slave    bus,
    output logic                   busy,
    output logic                   done
);
    localparam int ROW_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam int FL_W  = $clog2(2*ARR_SIZE);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(2*ARR_SIZE-2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ARR_SIZE-1);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [K_W-1:0]    klen_q;
    logic [K_W-1:0]    beat_q;
    logic [FL_W-1:0]   flush_q;
    logic [ROW_W-1:0]  row_q;
    logic              done_q;

    logic take, acc_en, clr_acc, row_hs, last_hs;

    logic [DATA_W-1:0]       a_op   [ARR_SIZE][ARR_SIZE];
    logic [DATA_W-1:0]       b_op   [ARR_SIZE][ARR_SIZE];
    logic signed [ACC_W-1:0] acc_row[ARR_SIZE][ARR_SIZE];

    // Low 2*DATA_W bits of the product are exact for both modes; extension picks the mode.
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic signed [2*DATA_W-1:0] ax, bx, ps;
        ax = {{DATA_W{sgn & a[DATA_W-1]}}, a};
        bx = {{DATA_W{sgn & b[DATA_W-1]}}, b};
        ps = ax * bx;
        if (sgn) mul_ext = ACC_W'(ps);
        else     mul_ext = ACC_W'($unsigned(ps));
    endfunction

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = (state_q != IDLE);
        take          = 1'b0;
        acc_en        = 1'b0;
        clr_acc       = 1'b0;
        row_hs        = 1'b0;
        last_hs       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_acc = 1'b1;
                    state_d = (k_len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                acc_en       = 1'b1;
                take         = bus.in_valid;
                if (take && beat_q == klen_q - K_W'(1)) state_d = FLUSH;
            end
            FLUSH: begin
                acc_en = 1'b1;
                if (flush_q == FLUSH_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                bus.out_valid = 1'b1;
                row_hs        = bus.out_ready;
                last_hs       = bus.out_ready && (row_q == ROW_LAST);
                if (last_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_hs;
            if (clr_acc) begin
                mode_q <= i_mode;
                klen_q <= k_len;
                beat_q <= '0;
            end else if (take) begin
                beat_q <= beat_q + K_W'(1);
            end
            if (state_q == FLUSH) flush_q <= flush_q + FL_W'(1);
            else                  flush_q <= '0;
            if (row_hs) row_q <= last_hs ? '0 : row_q + ROW_W'(1);
        end
    end

    assign done            = done_q;
    assign bus.out_row_idx = row_q;

    always_comb begin
        bus.out_data = '0;
        if (state_q == DRAIN) begin
            for (int j = 0; j < ARR_SIZE; j++) begin
                bus.out_data[j*ACC_W +: ACC_W] = acc_row[row_q][j];
            end
        end
    end

    genvar gi, gj;

    // Stage p0: per-lane skew lines; lane i delays by i extra cycles, bubbles enter as zero.
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_skew
        logic [DATA_W-1:0] a_dly_p0 [gi+1];
        logic [DATA_W-1:0] b_dly_p0 [gi+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= gi; k++) begin
                    a_dly_p0[k] <= '0;
                    b_dly_p0[k] <= '0;
                end
            end else begin
                a_dly_p0[0] <= take ? bus.a_col[gi*DATA_W +: DATA_W] : '0;
                b_dly_p0[0] <= take ? bus.b_row[gi*DATA_W +: DATA_W] : '0;
                for (int k = 1; k <= gi; k++) begin
                    a_dly_p0[k] <= a_dly_p0[k-1];
                    b_dly_p0[k] <= b_dly_p0[k-1];
                end
            end
        end

        assign a_op[gi][0] = a_dly_p0[gi];
        assign b_op[0][gi] = b_dly_p0[gi];
    end

    // Stage p1/p2: operands hop right/down one PE per cycle; each PE keeps its own sum.
    for (gi = 0; gi < ARR_SIZE; gi++) begin : g_row
        for (gj = 0; gj < ARR_SIZE; gj++) begin : g_pe
            logic signed [ACC_W-1:0] acc_p2;
            logic signed [ACC_W-1:0] prod;

            assign prod = mul_ext(a_op[gi][gj], b_op[gi][gj], mode_q);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst)         acc_p2 <= '0;
                else if (clr_acc) acc_p2 <= '0;
                else if (acc_en)  acc_p2 <= acc_p2 + prod;
            end

            assign acc_row[gi][gj] = acc_p2;

            if (gj < ARR_SIZE-1) begin : g_a_fwd
                logic [DATA_W-1:0] a_pe_p1;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_pe_p1 <= '0;
                    else      a_pe_p1 <= a_op[gi][gj];
                end
                assign a_op[gi][gj+1] = a_pe_p1;
            end

            if (gi < ARR_SIZE-1) begin : g_b_fwd
                logic [DATA_W-1:0] b_pe_p1;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_pe_p1 <= '0;
                    else      b_pe_p1 <= b_op[gi][gj];
                end
                assign b_op[gi+1][gj] = b_pe_p1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: drives operand beats, drains result rows
// and compares them to hand-computed or small-model expectations.
module tb_systolic_mm_engine;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 48;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_mode = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          busy;
    logic          done;

    systolic_mm_engine_if #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW)) bus();

    systolic_mm_engine #(.ARR_SIZE(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_mode (i_mode),
        .start  (start),
        .k_len  (k_len),
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] a_m [N][16];
    logic [DW-1:0] b_m [16][N];
    logic [AW-1:0] got [N][N];
    logic [AW-1:0] expc[N][N];
    int n_checks = 0;
    int n_errors = 0;
    int last_acc = 0;
    int lat = 0;
    string tname = "";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s/%s got=%0h exp=%0h", tname, tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int t);
        for (int i = 0; i < N; i++) begin
            bus.a_col[i*DW +: DW] = a_m[i][t];
            bus.b_row[i*DW +: DW] = b_m[t][i];
        end
    endtask

    // Golden product, accumulated in 64 bits and wrapped to the accumulator width.
    task automatic model(input bit mode, input int klen);
        longint s, av, bv;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int t = 0; t < klen; t++) begin
                    av = mode ? longint'($signed(a_m[r][t])) : longint'(a_m[r][t]);
                    bv = mode ? longint'($signed(b_m[t][c])) : longint'(b_m[t][c]);
                    s += av * bv;
                end
                expc[r][c] = s[AW-1:0];
            end
        end
    endtask

    // Mode and length are scrambled right after start to show they are latched.
    task automatic do_start(input bit mode, input int klen);
        i_mode = mode;
        k_len  = KW'(klen);
        start  = 1'b1;
        last_acc = cyc;
        tick();
        start  = 1'b0;
        i_mode = ~mode;
        k_len  = KW'(1);
    endtask

    task automatic send_beats(input int nb, input int g0, input int g1, input int glen,
                              input bit last_chk);
        for (int t = 0; t < nb; t++) begin
            if (t == g0 || t == g1) begin
                bus.in_valid = 1'b0;
                bus.a_col = '1;
                bus.b_row = '1;
                for (int s = 0; s < glen; s++) tick();
            end
            bus.in_valid = 1'b1;
            set_beat(t);
            check($sformatf("in_ready_b%0d", t), bus.in_ready, 1);
            last_acc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        if (last_chk) check("in_ready_flush", bus.in_ready, 0);
    endtask

    task automatic collect(input int stall_row, input int stall_len, input bit poke_start);
        int n;
        for (int r = 0; r < N; r++) begin
            n = 0;
            while (!bus.out_valid && n < 60) begin
                tick();
                n++;
            end
            check($sformatf("out_valid_r%0d", r), bus.out_valid, 1);
            if (r == 0) lat = cyc - last_acc;
            check($sformatf("row_idx_r%0d", r), bus.out_row_idx, r);
            for (int j = 0; j < N; j++) got[r][j] = bus.out_data[j*AW +: AW];
            if (r == stall_row) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check($sformatf("stall_valid_s%0d", s), bus.out_valid, 1);
                    check($sformatf("stall_idx_s%0d", s), bus.out_row_idx, r);
                    for (int j = 0; j < N; j++)
                        check($sformatf("stall_c%0d_%0d_s%0d", r, j, s),
                              bus.out_data[j*AW +: AW], expc[r][j]);
                end
                bus.out_ready = 1'b1;
            end
            if (poke_start && r == 2) begin
                start = 1'b1;
                k_len = KW'(4);
            end
            tick();
            start = 1'b0;
            if (poke_start && r == 2) check("busy_after_poke", busy, 1);
            if (r < N-1) check($sformatf("done_low_r%0d", r), done, 0);
        end
        check("done_pulse", done, 1);
        check("busy_idle", busy, 0);
        check("out_valid_idle", bus.out_valid, 0);
        tick();
        check("done_cleared", done, 0);
    endtask

    task automatic compare_results();
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                check($sformatf("c%0d_%0d", r, j), got[r][j], expc[r][j]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_data_lo"}, bus.out_data[63:0], 0);
        check({tag, "_data_hi"}, 64'(bus.out_data[N*AW-1:N*AW-64]), 0);
        check({tag, "_row_idx"}, bus.out_row_idx, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a_col     = '0;
        bus.b_row     = '0;
        bus.out_ready = 1'b1;

        tname = "reset";
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b1;
        tick();

        // Identity times B: C[r][j] = 10*r + j, first row 8 cycles after last accept
        tname = "identity";
        for (int i = 0; i < N; i++)
            for (int t = 0; t < N; t++) begin
                a_m[i][t] = (i == t) ? 16'd1 : 16'd0;
                b_m[t][i] = DW'(10*t + i);
            end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) expc[r][j] = AW'(10*r + j);
        do_start(1'b0, 4);
        check("busy_load", busy, 1);
        send_beats(4, -1, -1, 0, 1'b1);
        collect(-1, 0, 1'b0);
        compare_results();
        check("latency", lat, 8);

        tname = "signed_k1";
        for (int i = 0; i < N; i++) begin
            a_m[i][0] = 16'hFFFD;
            b_m[0][i] = 16'h0005;
        end
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) expc[r][j] = 48'hFFFF_FFFF_FFF1;
        do_start(1'b1, 1);
        send_beats(1, -1, -1, 0, 1'b1);
        collect(-1, 0, 1'b0);
        compare_results();

        tname = "unsigned_k1";
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) expc[r][j] = 48'h0000_0004_FFF1;
        do_start(1'b0, 1);
        send_beats(1, -1, -1, 0, 1'b1);
        collect(-1, 0, 1'b0);
        compare_results();

        tname = "rand_k7";
        for (int t = 0; t < 7; t++)
            for (int i = 0; i < N; i++) begin
                a_m[i][t] = DW'($urandom);
                b_m[t][i] = DW'($urandom);
            end
        model(1'b1, 7);
        do_start(1'b1, 7);
        send_beats(7, -1, -1, 0, 1'b1);
        collect(-1, 0, 1'b0);
        compare_results();

        tname = "rand_k7_gaps_stall";
        do_start(1'b1, 7);
        send_beats(7, 2, 5, 2, 1'b1);
        collect(1, 3, 1'b0);
        compare_results();

        // Abort in the middle of LOAD, then a clean k_len=4 unsigned job
        tname = "reset_mid_load";
        do_start(1'b1, 4);
        send_beats(3, -1, -1, 0, 1'b0);
        bus.in_valid = 1'b1;
        set_beat(3);
        #2 rst = 1'b0;
        #1 check_reset_outputs("abort");
        #2 rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        check("idle_after_abort", busy, 0);
        tname = "after_abort";
        model(1'b0, 4);
        do_start(1'b0, 4);
        send_beats(4, -1, -1, 0, 1'b1);
        collect(-1, 0, 1'b0);
        compare_results();

        // k_len=0 with live-looking operands: nothing is consumed, rows are zero
        tname = "k0";
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) expc[r][j] = '0;
        bus.in_valid = 1'b1;
        set_beat(0);
        do_start(1'b0, 0);
        check("k0_in_ready", bus.in_ready, 0);
        collect(-1, 0, 1'b1);
        compare_results();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("k0_no_restart", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
Output-stationary ARR_SIZE x ARR_SIZE systolic matrix-multiply engine. It generalises the bare MAC grid with on-chip input skewing, a job-control FSM, a k-length counter, signed/unsigned mode and a row-by-row result drain over a valid/ready handshake. It computes C = A(ARR_SIZE x k_len) * B(k_len x ARR_SIZE) per job and sits between the operand buffers and the result writeback path.

Parameters:
ARR_SIZE, 4, array rows/columns (128 at final synthesis)
DATA_W, 16, operand element width
ACC_W, 48, accumulator width; must satisfy ACC_W >= 2*DATA_W
K_W, 16, width of k_len

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
i_mode  in  1  0 = unsigned, 1 = signed (two's complement) multiply
start  in  1  begin job; sampled only in IDLE
k_len  in  K_W  number of operand beats; sampled with start
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts a beat
a_col  in  ARR_SIZE*DATA_W  column t of A; lane i = A[i][t]
b_row  in  ARR_SIZE*DATA_W  row t of B; lane j = B[t][j]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts a row
out_data  out  ARR_SIZE*ACC_W  C row out_row_idx; lane j = C[r][j]
out_row_idx  out  clog2(ARR_SIZE)  current row index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all accumulators, skew, pipeline registers and counters cleared; in_ready, out_valid, busy, done at 0; out_data and out_row_idx at 0.
- States: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: when start=1, latch i_mode and k_len, clear all accumulators and go to LOAD. If k_len=0, go to FLUSH instead.
- LOAD: in_ready=1. A beat is accepted on in_valid&in_ready, and the beat counter increments. If in_valid=0, a zero bubble enters the array, which advances every cycle regardless. After beat k_len-1 is accepted, go to FLUSH.
- Skewing: lane i of a_col is delayed by i cycles; lane j of b_row is delayed by j cycles. A values shift right one PE per cycle and B values shift down one PE per cycle. PE(i,j) multiplies the operands of beat t in cycle t_acc+1+i+j, where t_acc is the accept cycle, and adds the product at the end of that cycle.
- FLUSH: in_ready=0. Zeros are injected for exactly 2*ARR_SIZE-1 cycles, then go to DRAIN. With the last beat accepted in cycle T, out_valid first rises in cycle T+2*ARR_SIZE.
- Arithmetic: the product is 2*DATA_W bits. It is sign-extended (mode 1) or zero-extended (mode 0) to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation.
- DRAIN: out_valid=1 and out_data = accumulators of row out_row_idx, starting at 0. out_data and out_row_idx hold stable while out_valid&!out_ready. On handshake, the row index increments. The handshake on row ARR_SIZE-1 returns the FSM to IDLE with done=1 for that one cycle; the row index resets to 0.
- start outside IDLE is ignored. Changes to i_mode and k_len mid-job are ignored.
- in_valid outside LOAD is ignored; no beat is consumed.
- Reset mid-job aborts immediately. No partial results are emitted, and the next job is unaffected.

Test Plan:
- ARR_SIZE=4, unsigned, A=identity, B[t][j]=10*t+j, k_len=4 -> rows emitted in order, C[r][j]=10*r+j, done pulses once, first out_valid 8 cycles after last accept.
- i_mode=1, all a lanes 16'hFFFD, all b lanes 16'h0005, k_len=1 -> every lane 48'hFFFF_FFFF_FFF1. Same with i_mode=0 -> every lane 48'h0000_0004_FFF1.
- Random A/B, k_len=7, in_valid deasserted on beats 2 and 5 for 2 cycles each -> results match the golden matmul and the no-gap run.
- out_ready low for 3 cycles on row 1 -> out_data and out_row_idx=1 stay stable, no row skipped or duplicated.
- rst pulsed low during LOAD beat 3 -> all outputs 0 within the reset, state IDLE. A subsequent k_len=4 job gives correct results.
- k_len=0 -> 4 all-zero rows emitted. A start asserted during DRAIN is ignored: busy stays 1 and exactly 4 rows are emitted.
